// File: rtl/spi_rx_pkg.sv
// Shared constants and types for the SPI byte receiver that feeds the FIFO write side.
package spi_rx_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned SPI_BITS_W = $clog2(DATA_WIDTH);
  localparam int unsigned HOLD_DEPTH = 2;
  localparam logic        CS_IDLE    = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rxState_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a selectable reset level.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic Clk,
  input  logic reset,
  input  logic pinAsync,
  output logic pinSync
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], pinAsync};
    end
  end

  assign pinSync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_byte_receiver.sv
// Oversampling SPI (mode 0, MSB first) byte receiver with a small hold queue
// presenting bytes to the FIFO write side under haltInput back-pressure.
module spi_byte_receiver #(
  parameter int unsigned DATA_WIDTH  = spi_rx_pkg::DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_DEPTH  = spi_rx_pkg::HOLD_DEPTH
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  spiSclk,
  input  logic                  spiMosi,
  input  logic                  spiCsN,
  input  logic                  haltInput,
  input  logic                  clearOvf,
  output logic                  Control,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  overflow,
  output logic                  frameActive,
  output logic [7:0]            byteCount
);

  import spi_rx_pkg::*;

  localparam int unsigned BitW  = $clog2(DATA_WIDTH);
  localparam int unsigned AddrW = $clog2(HOLD_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic syncSclk;
  logic syncMosi;
  logic syncCsN;
  logic sclkPrev;
  logic sclkRise;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSclk (
    .Clk      (Clk),
    .reset    (reset),
    .pinAsync (spiSclk),
    .pinSync  (syncSclk)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncMosi (
    .Clk      (Clk),
    .reset    (reset),
    .pinAsync (spiMosi),
    .pinSync  (syncMosi)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) uSyncCsN (
    .Clk      (Clk),
    .reset    (reset),
    .pinAsync (spiCsN),
    .pinSync  (syncCsN)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      sclkPrev <= 1'b0;
    end else begin
      sclkPrev <= syncSclk;
    end
  end

  assign sclkRise = syncSclk & ~sclkPrev;

  // Shift/bit-count FSM: state register plus next-state logic.
  rxState_e              state;
  rxState_e              stateNext;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [DATA_WIDTH-1:0] shiftNext;
  logic [DATA_WIDTH-1:0] shiftWord;
  logic [BitW-1:0]       bitCount;
  logic [BitW-1:0]       bitCountNext;
  logic [7:0]            byteCountNext;
  logic                  pushValid;

  assign shiftWord = {shiftReg[DATA_WIDTH-2:0], syncMosi};

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitCount  <= '0;
      byteCount <= '0;
    end else begin
      state     <= stateNext;
      shiftReg  <= shiftNext;
      bitCount  <= bitCountNext;
      byteCount <= byteCountNext;
    end
  end

  always_comb begin
    stateNext     = state;
    shiftNext     = shiftReg;
    bitCountNext  = bitCount;
    byteCountNext = byteCount;
    pushValid     = 1'b0;
    case (state)
      IDLE: begin
        if (syncCsN != CS_IDLE) begin
          stateNext     = SHIFT;
          shiftNext     = '0;
          bitCountNext  = '0;
          byteCountNext = '0;
        end
      end
      SHIFT: begin
        // Chip-select release wins over any coincident clock edge; partial byte is lost.
        if (syncCsN == CS_IDLE) begin
          stateNext    = IDLE;
          shiftNext    = '0;
          bitCountNext = '0;
        end else if (sclkRise) begin
          shiftNext = shiftWord;
          if (bitCount == BitW'(DATA_WIDTH - 1)) begin
            pushValid     = 1'b1;
            bitCountNext  = '0;
            byteCountNext = byteCount + 8'd1;
          end else begin
            bitCountNext = bitCount + BitW'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign frameActive = (state == SHIFT);

  // Hold queue: extra wrap bit on each pointer distinguishes full from empty.
  logic [DATA_WIDTH-1:0] holdMem [HOLD_DEPTH];
  logic [PtrW-1:0]       wrPtr;
  logic [PtrW-1:0]       rdPtr;
  logic                  full;
  logic                  pop;
  logic                  pushAccept;
  logic                  drop;

  assign full       = (wrPtr[AddrW] != rdPtr[AddrW]) &&
                      (wrPtr[AddrW-1:0] == rdPtr[AddrW-1:0]);
  assign Control    = (wrPtr != rdPtr);
  assign pop        = Control & ~haltInput;
  assign pushAccept = pushValid & (~full | pop);
  assign drop       = pushValid & full & ~pop;
  assign dataOut    = holdMem[rdPtr[AddrW-1:0]];

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(HOLD_DEPTH); i++) begin
        holdMem[i] <= '0;
      end
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushAccept) begin
        holdMem[wrPtr[AddrW-1:0]] <= shiftWord;
        wrPtr                     <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clearOvf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed self-checking bench for spi_byte_receiver (Clk = 8x SPI clock).
module tb_spi_byte_receiver;

  logic       Clk = 1'b0;
  logic       reset;
  logic       spiSclk;
  logic       spiMosi;
  logic       spiCsN;
  logic       haltInput;
  logic       clearOvf;
  logic       Control;
  logic [7:0] dataOut;
  logic       overflow;
  logic       frameActive;
  logic [7:0] byteCount;

  int passCount = 0;
  int checkCount = 0;
  logic [7:0] got[$];

  spi_byte_receiver dut (
    .Clk         (Clk),
    .reset       (reset),
    .spiSclk     (spiSclk),
    .spiMosi     (spiMosi),
    .spiCsN      (spiCsN),
    .haltInput   (haltInput),
    .clearOvf    (clearOvf),
    .Control     (Control),
    .dataOut     (dataOut),
    .overflow    (overflow),
    .frameActive (frameActive),
    .byteCount   (byteCount)
  );

  always #5 Clk = ~Clk;

  // Record every byte the FIFO side accepts
  always @(posedge Clk) begin
    if (reset && Control && !haltInput) got.push_back(dataOut);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic spiBit(input logic b);
    spiSclk = 1'b0;
    spiMosi = b;
    waitClk(4);
    spiSclk = 1'b1;
    waitClk(4);
  endtask

  task automatic spiBits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) spiBit(v[7-i]);
  endtask

  task automatic csLow();
    spiCsN = 1'b0;
    waitClk(4);
  endtask

  task automatic csHigh();
    spiSclk = 1'b0;
    waitClk(2);
    spiCsN = 1'b1;
    waitClk(8);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    spiSclk = 1'b0; spiMosi = 1'b0; spiCsN = 1'b1;
    haltInput = 1'b0; clearOvf = 1'b0;
    waitClk(3);
    reset = 1'b1;
    waitClk(4);
    checkCount++; if (Control !== 1'b0) $display("FAIL reset_control: got %b expected 0", Control); else passCount++;
    checkCount++; if (dataOut !== 8'h00) $display("FAIL reset_dataOut: got %h expected 00", dataOut); else passCount++;
    checkCount++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passCount++;
    checkCount++; if (frameActive !== 1'b0) $display("FAIL reset_frameActive: got %b expected 0", frameActive); else passCount++;
    checkCount++; if (byteCount !== 8'd0) $display("FAIL reset_byteCount: got %0d expected 0", byteCount); else passCount++;
  endtask

  task automatic test_sclk_idle();
    got.delete();
    for (int i = 0; i < 10; i++) spiBit(1'b1);
    spiSclk = 1'b0;
    waitClk(6);
    checkCount++; if (got.size() != 0) $display("FAIL idle_bytes: got %0d bytes expected 0", got.size()); else passCount++;
    checkCount++; if (byteCount !== 8'd0) $display("FAIL idle_byteCount: got %0d expected 0", byteCount); else passCount++;
    checkCount++; if (Control !== 1'b0) $display("FAIL idle_control: got %b expected 0", Control); else passCount++;
  endtask

  task automatic test_single();
    got.delete();
    csLow();
    checkCount++; if (frameActive !== 1'b1) $display("FAIL single_frameActive: got %b expected 1", frameActive); else passCount++;
    spiBits(8'hA5, 7);
    spiSclk = 1'b0; spiMosi = 1'b1;
    waitClk(4);
    spiSclk = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1;
    checkCount++; if (Control !== 1'b0) $display("FAIL single_latency_early: got %b expected 0", Control); else passCount++;
    @(posedge Clk); #1;
    checkCount++; if (Control !== 1'b1) $display("FAIL single_latency_control: got %b expected 1", Control); else passCount++;
    checkCount++; if (dataOut !== 8'hA5) $display("FAIL single_dataOut: got %h expected a5", dataOut); else passCount++;
    @(negedge Clk);
    waitClk(3);
    csHigh();
    checkCount++; if (got.size() != 1) $display("FAIL single_count: got %0d bytes expected 1", got.size()); else passCount++;
    checkCount++; if (got.size() > 0 && got[0] !== 8'hA5) $display("FAIL single_byte: got %h expected a5", got[0]); else passCount++;
    checkCount++; if (byteCount !== 8'd1) $display("FAIL single_byteCount: got %0d expected 1", byteCount); else passCount++;
    checkCount++; if (overflow !== 1'b0) $display("FAIL single_overflow: got %b expected 0", overflow); else passCount++;
  endtask

  task automatic test_halt_overflow();
    logic [7:0] exp[2] = '{8'h01, 8'h02};
    got.delete();
    haltInput = 1'b1;
    csLow();
    spiBits(8'h01, 8);
    spiBits(8'h02, 8);
    spiBits(8'h03, 8);
    csHigh();
    checkCount++; if (Control !== 1'b1) $display("FAIL halt_control: got %b expected 1", Control); else passCount++;
    checkCount++; if (dataOut !== 8'h01) $display("FAIL halt_dataOut: got %h expected 01", dataOut); else passCount++;
    checkCount++; if (overflow !== 1'b1) $display("FAIL halt_overflow: got %b expected 1", overflow); else passCount++;
    checkCount++; if (byteCount !== 8'd3) $display("FAIL halt_byteCount: got %0d expected 3", byteCount); else passCount++;
    haltInput = 1'b0;
    waitClk(4);
    checkCount++; if (got.size() != 2) $display("FAIL halt_release_count: got %0d bytes expected 2", got.size()); else passCount++;
    for (int i = 0; i < 2; i++) begin
      checkCount++; if (got.size() > i && got[i] !== exp[i]) $display("FAIL halt_release_byte%0d: got %h expected %h", i, got[i], exp[i]); else passCount++;
    end
    checkCount++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else passCount++;
    clearOvf = 1'b1;
    @(posedge Clk); #1;
    checkCount++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow); else passCount++;
    @(negedge Clk);
    clearOvf = 1'b0;
    waitClk(2);
  endtask

  task automatic test_full_pop_same_edge();
    logic [7:0] exp[3] = '{8'h01, 8'h02, 8'h03};
    got.delete();
    haltInput = 1'b1;
    csLow();
    spiBits(8'h01, 8);
    spiBits(8'h02, 8);
    spiBits(8'h03, 7);
    spiSclk = 1'b0; spiMosi = 1'b1;
    waitClk(4);
    spiSclk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    checkCount++; if (dataOut !== 8'h01) $display("FAIL fullpop_head_before: got %h expected 01", dataOut); else passCount++;
    haltInput = 1'b0;
    @(posedge Clk); #1;
    checkCount++; if (dataOut !== 8'h02) $display("FAIL fullpop_head_after: got %h expected 02", dataOut); else passCount++;
    checkCount++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b expected 0", overflow); else passCount++;
    @(negedge Clk);
    waitClk(4);
    csHigh();
    checkCount++; if (got.size() != 3) $display("FAIL fullpop_count: got %0d bytes expected 3", got.size()); else passCount++;
    for (int i = 0; i < 3; i++) begin
      checkCount++; if (got.size() > i && got[i] !== exp[i]) $display("FAIL fullpop_byte%0d: got %h expected %h", i, got[i], exp[i]); else passCount++;
    end
    checkCount++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow_end: got %b expected 0", overflow); else passCount++;
  endtask

  task automatic test_abort();
    got.delete();
    haltInput = 1'b0;
    csLow();
    spiBits(8'hFF, 5);
    csHigh();
    csLow();
    spiBits(8'h3C, 8);
    csHigh();
    checkCount++; if (got.size() != 1) $display("FAIL abort_count: got %0d bytes expected 1", got.size()); else passCount++;
    checkCount++; if (got.size() > 0 && got[0] !== 8'h3C) $display("FAIL abort_byte: got %h expected 3c", got[0]); else passCount++;
    checkCount++; if (byteCount !== 8'd1) $display("FAIL abort_byteCount: got %0d expected 1", byteCount); else passCount++;
  endtask

  task automatic test_reset_mid();
    got.delete();
    haltInput = 1'b1;
    csLow();
    spiBits(8'h01, 8);
    spiBits(8'h02, 8);
    spiBits(8'h03, 8);
    spiBits(8'hF0, 4);
    checkCount++; if (overflow !== 1'b1) $display("FAIL rstmid_pre_overflow: got %b expected 1", overflow); else passCount++;
    reset = 1'b0;
    #1;
    checkCount++; if (Control !== 1'b0) $display("FAIL rstmid_control: got %b expected 0", Control); else passCount++;
    checkCount++; if (overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b expected 0", overflow); else passCount++;
    checkCount++; if (dataOut !== 8'h00) $display("FAIL rstmid_dataOut: got %h expected 00", dataOut); else passCount++;
    checkCount++; if (byteCount !== 8'd0) $display("FAIL rstmid_byteCount: got %0d expected 0", byteCount); else passCount++;
    spiCsN = 1'b1; spiSclk = 1'b0; haltInput = 1'b0;
    waitClk(2);
    reset = 1'b1;
    waitClk(4);
    checkCount++; if (Control !== 1'b0) $display("FAIL rstmid_post_control: got %b expected 0", Control); else passCount++;
    csLow();
    spiBits(8'h5A, 8);
    csHigh();
    checkCount++; if (got.size() != 1) $display("FAIL rstmid_count: got %0d bytes expected 1", got.size()); else passCount++;
    checkCount++; if (got.size() > 0 && got[0] !== 8'h5A) $display("FAIL rstmid_byte: got %h expected 5a", got[0]); else passCount++;
    checkCount++; if (byteCount !== 8'd1) $display("FAIL rstmid_byteCount_after: got %0d expected 1", byteCount); else passCount++;
  endtask

  initial begin
    test_reset();
    test_sclk_idle();
    test_single();
    test_halt_overflow();
    test_full_pop_same_edge();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
